// File: rtl/ext_pkg.sv
// Shared definitions for the extender pipeline: ext_op encodings and widths.
package ext_pkg;

    localparam int EXT_OP_W = 3;

    typedef enum logic [EXT_OP_W-1:0] {
        EXT_ZERO     = 3'd0,
        EXT_LUI      = 3'd1,
        EXT_SIGN     = 3'd2,
        EXT_SIGN_SL2 = 3'd3,
        EXT_LB       = 3'd4,
        EXT_LBU      = 3'd5,
        EXT_LH       = 3'd6,
        EXT_LHU      = 3'd7
    } ext_op_e;

endpackage

// File: rtl/ext_pipe_if.sv
// Request/response bundle between a producer stage, the extender and its consumer.
interface ext_pipe_if
    import ext_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16
);
    localparam int OFF_W = $clog2(DATA_W / 8);

    logic                in_valid;
    logic                in_ready;
    logic [EXT_OP_W-1:0] ext_op;
    logic [IMM_W-1:0]    imm;
    logic [DATA_W-1:0]   mem_data;
    logic [OFF_W-1:0]    byte_off;
    logic                out_valid;
    logic                out_ready;
    logic [DATA_W-1:0]   out_data;
    logic                out_misalign;

    // Surrounding pipeline: issues requests and consumes results.
    modport master (
        output in_valid, ext_op, imm, mem_data, byte_off, out_ready,
        input  in_ready, out_valid, out_data, out_misalign
    );

    // Extender: accepts requests and presents buffered results.
    modport slave (
        input  in_valid, ext_op, imm, mem_data, byte_off, out_ready,
        output in_ready, out_valid, out_data, out_misalign
    );

endinterface

// File: rtl/ext_core.sv
// Combinational extension mux: immediate forms and little-endian load lane extraction.
module ext_core
    import ext_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16,
    localparam int OFF_W = $clog2(DATA_W / 8)
) (
    input  logic [EXT_OP_W-1:0] ext_op,
    input  logic [IMM_W-1:0]    imm,
    input  logic [DATA_W-1:0]   mem_data,
    input  logic [OFF_W-1:0]    byte_off,
    output logic [DATA_W-1:0]   data,
    output logic                misalign
);

    logic [DATA_W-1:0] imm_sext;
    logic [7:0]        lane_b;
    logic [15:0]       lane_h;

    // Operand preparation: sign-extended immediate and the selected byte/halfword lanes.
    always_comb begin
        imm_sext = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
        lane_b   = mem_data[{byte_off, 3'b000} +: 8];
        lane_h   = mem_data[{byte_off[OFF_W-1:1], 4'b0000} +: 16];
    end

    // Mode select; odd-offset halfword loads yield zero data with the misalign flag.
    always_comb begin
        data     = '0;
        misalign = 1'b0;
        case (ext_op_e'(ext_op))
            EXT_ZERO:     data = {{(DATA_W-IMM_W){1'b0}}, imm};
            EXT_LUI:      data = {imm, {(DATA_W-IMM_W){1'b0}}};
            EXT_SIGN:     data = imm_sext;
            EXT_SIGN_SL2: data = {imm_sext[DATA_W-3:0], 2'b00};
            EXT_LB:       data = {{(DATA_W-8){lane_b[7]}}, lane_b};
            EXT_LBU:      data = {{(DATA_W-8){1'b0}}, lane_b};
            EXT_LH: begin
                if (byte_off[0]) misalign = 1'b1;
                else             data = {{(DATA_W-16){lane_h[15]}}, lane_h};
            end
            EXT_LHU: begin
                if (byte_off[0]) misalign = 1'b1;
                else             data = {{(DATA_W-16){1'b0}}, lane_h};
            end
            default: begin
                data     = '0;
                misalign = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/ext_pipe.sv
// Registered extender: ext_core result captured into a 2-entry FIFO with valid/ready and flush.
module ext_pipe
    import ext_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      flush,
    ext_pipe_if.slave bus
);

    logic [DATA_W-1:0] core_data;
    logic              core_mis;

    logic [DATA_W-1:0] data_q [2];
    logic              mis_q  [2];
    logic [1:0]        count_q, count_d;
    logic              head_q, head_d;
    logic              tail_q, tail_d;
    logic              push, pop, wr_en;

    ext_core #(
        .DATA_W (DATA_W),
        .IMM_W  (IMM_W)
    ) u_core (
        .ext_op   (bus.ext_op),
        .imm      (bus.imm),
        .mem_data (bus.mem_data),
        .byte_off (bus.byte_off),
        .data     (core_data),
        .misalign (core_mis)
    );

    // Handshake outputs derive only from registered state.
    assign bus.in_ready     = (count_q != 2'd2);
    assign bus.out_valid    = (count_q != 2'd0);
    assign bus.out_data     = data_q[head_q];
    assign bus.out_misalign = mis_q[head_q];

    // Pointer/count next state; flush overrides any same-cycle push or pop.
    always_comb begin
        push    = bus.in_valid & bus.in_ready;
        pop     = bus.out_valid & bus.out_ready;
        wr_en   = push & ~flush;
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (flush) begin
            count_d = '0;
            head_d  = 1'b0;
            tail_d  = 1'b0;
        end else begin
            if (push) tail_d = ~tail_q;
            if (pop)  head_d = ~head_q;
            case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    // FIFO state and entry storage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
            head_q  <= 1'b0;
            tail_q  <= 1'b0;
            for (int unsigned i = 0; i < 2; i++) begin
                data_q[i] <= '0;
                mis_q[i]  <= 1'b0;
            end
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            if (wr_en) begin
                data_q[tail_q] <= core_data;
                mis_q[tail_q]  <= core_mis;
            end
        end
    end

endmodule

// File: tb/tb_ext_pipe.sv
// Directed self-checking bench for ext_pipe (DATA_W=32, IMM_W=16).
module tb_ext_pipe;
    import ext_pkg::*;

    logic clk;
    logic reset;
    logic flush;
    int   vectors;
    int   miscompares;

    ext_pipe_if #(.DATA_W(32), .IMM_W(16)) bus ();

    ext_pipe #(.DATA_W(32), .IMM_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic [2:0] op, input logic [15:0] im,
                         input logic [31:0] md, input logic [1:0] off);
        bus.in_valid = v;
        bus.ext_op   = op;
        bus.imm      = im;
        bus.mem_data = md;
        bus.byte_off = off;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.out_ready = 1'b0;
        drive(1'b1, 3'd2, 16'h8001, 32'h0, 2'd0);
        repeat (2) @(negedge clk);
        vectors++;
        if (bus.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_out_valid got=%b want=0", bus.out_valid);
        end
        vectors++;
        if (bus.out_data !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_out_data got=%h want=00000000", bus.out_data);
        end
        vectors++;
        if (bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_in_ready got=%b want=1", bus.in_ready);
        end
        reset = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 32'hFFFF8001) begin
            miscompares++;
            $display("FAIL first_push got v=%b d=%h want v=1 d=ffff8001", bus.out_valid, bus.out_data);
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (bus.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL first_drain got=%b want=0", bus.out_valid);
        end
    endtask

    task automatic test_imm();
        logic [2:0]  ops [4];
        logic [15:0] imms [4];
        logic [31:0] exps [4];
        ops[0] = 3'd0; imms[0] = 16'hF0F0; exps[0] = 32'h0000F0F0;
        ops[1] = 3'd1; imms[1] = 16'h1234; exps[1] = 32'h12340000;
        ops[2] = 3'd2; imms[2] = 16'h7FFF; exps[2] = 32'h00007FFF;
        ops[3] = 3'd3; imms[3] = 16'hFFFF; exps[3] = 32'hFFFFFFFC;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, ops[i], imms[i], 32'hDEADBEEF, 2'd3);
            @(negedge clk);
            vectors++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== exps[i] || bus.out_misalign !== 1'b0) begin
                miscompares++;
                $display("FAIL imm_op%0d got v=%b d=%h m=%b want v=1 d=%h m=0",
                         i, bus.out_valid, bus.out_data, bus.out_misalign, exps[i]);
            end
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (bus.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL imm_drain got=%b want=0", bus.out_valid);
        end
    endtask

    task automatic test_load();
        logic [2:0]  ops [6];
        logic [1:0]  offs [6];
        logic [31:0] exps [6];
        logic        mis [6];
        ops[0] = 3'd4; offs[0] = 2'd2; exps[0] = 32'hFFFFFFFF; mis[0] = 1'b0;
        ops[1] = 3'd5; offs[1] = 2'd3; exps[1] = 32'h00000080; mis[1] = 1'b0;
        ops[2] = 3'd6; offs[2] = 2'd2; exps[2] = 32'hFFFF80FF; mis[2] = 1'b0;
        ops[3] = 3'd7; offs[3] = 2'd0; exps[3] = 32'h00007F01; mis[3] = 1'b0;
        ops[4] = 3'd6; offs[4] = 2'd1; exps[4] = 32'h00000000; mis[4] = 1'b1;
        ops[5] = 3'd7; offs[5] = 2'd2; exps[5] = 32'h000080FF; mis[5] = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, ops[i], 16'hA5A5, 32'h80FF7F01, offs[i]);
            @(negedge clk);
            vectors++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== exps[i] || bus.out_misalign !== mis[i]) begin
                miscompares++;
                $display("FAIL load_%0d got v=%b d=%h m=%b want v=1 d=%h m=%b",
                         i, bus.out_valid, bus.out_data, bus.out_misalign, exps[i], mis[i]);
            end
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        drive(1'b1, 3'd0, 16'hAAAA, 32'h0, 2'd0);
        @(negedge clk);
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b1 || bus.out_data !== 32'h0000AAAA) begin
            miscompares++;
            $display("FAIL bp_one got v=%b r=%b d=%h want v=1 r=1 d=0000aaaa", bus.out_valid, bus.in_ready, bus.out_data);
        end
        drive(1'b1, 3'd0, 16'hBBBB, 32'h0, 2'd0);
        @(negedge clk);
        vectors++;
        if (bus.in_ready !== 1'b0 || bus.out_data !== 32'h0000AAAA) begin
            miscompares++;
            $display("FAIL bp_full got r=%b d=%h want r=0 d=0000aaaa", bus.in_ready, bus.out_data);
        end
        drive(1'b1, 3'd0, 16'hCCCC, 32'h0, 2'd0);
        @(negedge clk);
        vectors++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_data !== 32'h0000AAAA) begin
            miscompares++;
            $display("FAIL bp_stall got r=%b v=%b d=%h want r=0 v=1 d=0000aaaa", bus.in_ready, bus.out_valid, bus.out_data);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b1 || bus.out_data !== 32'h0000BBBB) begin
            miscompares++;
            $display("FAIL bp_second got v=%b r=%b d=%h want v=1 r=1 d=0000bbbb", bus.out_valid, bus.in_ready, bus.out_data);
        end
        drive(1'b1, 3'd0, 16'hDDDD, 32'h0, 2'd0);
        @(negedge clk);
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b1 || bus.out_data !== 32'h0000DDDD) begin
            miscompares++;
            $display("FAIL bp_pushpop got v=%b r=%b d=%h want v=1 r=1 d=0000dddd", bus.out_valid, bus.in_ready, bus.out_data);
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (bus.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_drain got v=%b d=%h want v=0", bus.out_valid, bus.out_data);
        end
    endtask

    task automatic test_flush();
        bus.out_ready = 1'b0;
        drive(1'b1, 3'd0, 16'h1111, 32'h0, 2'd0);
        @(negedge clk);
        drive(1'b1, 3'd0, 16'h2222, 32'h0, 2'd0);
        @(negedge clk);
        vectors++;
        if (bus.in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_prefill got r=%b want r=0", bus.in_ready);
        end
        flush = 1'b1;
        drive(1'b1, 3'd0, 16'h3333, 32'h0, 2'd0);
        @(negedge clk);
        flush = 1'b0;
        bus.in_valid = 1'b0;
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL flush_clear got v=%b r=%b want v=0 r=1", bus.out_valid, bus.in_ready);
        end
        @(negedge clk);
        vectors++;
        if (bus.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_dropped got v=%b d=%h want v=0", bus.out_valid, bus.out_data);
        end
        bus.out_ready = 1'b1;
        drive(1'b1, 3'd2, 16'h8444, 32'h0, 2'd0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 32'hFFFF8444) begin
            miscompares++;
            $display("FAIL flush_resume got v=%b d=%h want v=1 d=ffff8444", bus.out_valid, bus.out_data);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 1'b0;
        drive(1'b1, 3'd0, 16'h5555, 32'h0, 2'd0);
        repeat (2) @(negedge clk);
        bus.in_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_data !== 32'h0 || bus.out_misalign !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid got v=%b r=%b d=%h m=%b want v=0 r=1 d=00000000 m=0",
                     bus.out_valid, bus.in_ready, bus.out_data, bus.out_misalign);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        vectors++;
        if (bus.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_after got v=%b want v=0", bus.out_valid);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b0;
        flush       = 1'b0;
        bus.out_ready = 1'b0;
        drive(1'b0, 3'd0, 16'h0, 32'h0, 2'd0);
        test_reset();
        test_imm();
        test_load();
        test_backpressure();
        test_flush();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
